// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-initiator to 1-target Wishbone classic round-robin arbiter.
// The grant is held for a whole bus cycle (cyc). Arbitration is registered, so there
// is one idle cycle between consecutive grants.
// Optional feature macro: WB_ARB_TIMEOUT_EN adds a stuck-target watchdog and a DRAIN state.
//
// Handshake: a target transfer completes in any cycle where tcyc_o & tstb_o & (tack_i | terr_i)
// are all high. The owner sees ack_o[g]/err_o[g] in that same cycle. Non-owners keep cyc high
// and wait; they are never acked.
module wb_arbiter_rr #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_INITIATORS   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clock_i,
    input  logic                                     reset_i,
    input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]    adr_i,
    input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]    dat_w_i,
    output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]    dat_r_o,
    input  logic [N_INITIATORS-1:0]                  cyc_i,
    input  logic [N_INITIATORS-1:0]                  stb_i,
    input  logic [N_INITIATORS-1:0]                  we_i,
    input  logic [N_INITIATORS*WB_DATA_WIDTH/8-1:0]  sel_i,
    output logic [N_INITIATORS-1:0]                  ack_o,
    output logic [N_INITIATORS-1:0]                  err_o,
    output logic [WB_ADDR_WIDTH-1:0]                 tadr_o,
    output logic [WB_DATA_WIDTH-1:0]                 tdat_w_o,
    input  logic [WB_DATA_WIDTH-1:0]                 tdat_r_i,
    output logic                                     tcyc_o,
    output logic                                     tstb_o,
    output logic                                     twe_o,
    output logic [WB_DATA_WIDTH/8-1:0]               tsel_o,
    input  logic                                     tack_i,
    input  logic                                     terr_i,
    output logic [N_INITIATORS-1:0]                  gnt_o,
    output logic [1:0]                               state_o
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int N  = N_INITIATORS;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Reject out-of-range configurations at elaboration time.
    if (N_INITIATORS < 2 || N_INITIATORS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_bad_params
        $error("wb_arbiter_rr: parameter out of range");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1
    } state_e;
`endif

    state_e          state_q;
    logic [N-1:0]    gnt_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_q;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            busy;
    logic            owner_cyc;
    logic            timeout_hit;
    logic            fwd;

    assign busy      = (state_q == ST_BUSY);
    assign owner_cyc = cyc_i[owner_q];
    assign gnt_o     = gnt_q;
    assign state_o   = state_q;

    // Round-robin pick: first requester scanning last+1, last+2 ... modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!pick_found && cyc_i[IW'((int'(last_q) + k) % N)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(last_q) + k) % N);
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    assign timeout_hit = busy && (to_cnt_q == 16'(TIMEOUT_CYCLES));

    // Watchdog: counts strobed BUSY cycles without a target response.
    always_ff @(posedge clock_i) begin
        if (reset_i || !busy) begin
            to_cnt_q <= '0;
        end else if (tack_i || terr_i) begin
            to_cnt_q <= '0;
        end else if (tstb_o) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Target side only carries the owner's signals while it holds cyc; zero otherwise.
    assign fwd = busy && owner_cyc && !timeout_hit;

    // Target mux and per-initiator response steering.
    always_comb begin
        tcyc_o   = fwd;
        tstb_o   = fwd & stb_i[owner_q];
        twe_o    = fwd & we_i[owner_q];
        tadr_o   = fwd ? adr_i[owner_q*AW +: AW]   : '0;
        tdat_w_o = fwd ? dat_w_i[owner_q*DW +: DW] : '0;
        tsel_o   = fwd ? sel_i[owner_q*SW +: SW]   : '0;
        ack_o    = '0;
        err_o    = '0;
        if (busy) begin
            ack_o[owner_q] = tack_i;
            err_o[owner_q] = terr_i | timeout_hit;
        end
    end

    // Read data is broadcast; only the owner's ack qualifies it.
    assign dat_r_o = {N{tdat_r_i}};

    // Arbitration FSM: grant, hold for the whole cycle, release to IDLE.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q <= ST_BUSY;
                        owner_q <= pick_idx;
                        gnt_q   <= N'(1) << pick_idx;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!owner_cyc) begin
                        state_q <= ST_IDLE;
                        last_q  <= owner_q;
                        gnt_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state_q <= ST_DRAIN;
`endif
                    end
                end
`ifdef WB_ARB_TIMEOUT_EN
                ST_DRAIN: begin
                    if (!owner_cyc) begin
                        state_q <= ST_IDLE;
                        last_q  <= owner_q;
                        gnt_q   <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed testbench for wb_arbiter_rr (N=4, 32-bit, TIMEOUT_CYCLES=8).
module tb_wb_arbiter_rr;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // clock / reset
  logic clock_i = 1'b0;
  logic reset_i;
  always #5 clock_i = ~clock_i;

  logic [N*AW-1:0] adr_i;
  logic [N*DW-1:0] dat_w_i;
  logic [N*DW-1:0] dat_r_o;
  logic [N-1:0]    cyc_i, stb_i, we_i;
  logic [N*SW-1:0] sel_i;
  logic [N-1:0]    ack_o, err_o, gnt_o;
  logic [AW-1:0]   tadr_o;
  logic [DW-1:0]   tdat_w_o, tdat_r_i;
  logic            tcyc_o, tstb_o, twe_o, tack_i, terr_i;
  logic [SW-1:0]   tsel_o;
  logic [1:0]      state_o;

  wb_arbiter_rr #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .N_INITIATORS  (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .adr_i   (adr_i),
    .dat_w_i (dat_w_i),
    .dat_r_o (dat_r_o),
    .cyc_i   (cyc_i),
    .stb_i   (stb_i),
    .we_i    (we_i),
    .sel_i   (sel_i),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .tadr_o  (tadr_o),
    .tdat_w_o(tdat_w_o),
    .tdat_r_i(tdat_r_i),
    .tcyc_o  (tcyc_o),
    .tstb_o  (tstb_o),
    .twe_o   (twe_o),
    .tsel_o  (tsel_o),
    .tack_i  (tack_i),
    .terr_i  (terr_i),
    .gnt_o   (gnt_o),
    .state_o (state_o)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clock_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_bus();
    cyc_i  = '0;
    stb_i  = '0;
    we_i   = '0;
    tack_i = 1'b0;
    terr_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    next_cycle();
    next_cycle();
    reset_i = 1'b0;
  endtask

  task automatic request(input int idx, input logic on);
    cyc_i[idx] = on;
    stb_i[idx] = on;
  endtask

  initial begin
    reset_i  = 1'b1;
    quiet_bus();
    sel_i    = '1;
    tdat_r_i = 32'h0;
    for (int i = 0; i < N; i++) begin
      adr_i[i*AW +: AW]   = 32'h1000_0000 + 32'(i) * 32'h100;
      dat_w_i[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end

    // ---- reset state ----
    do_reset();
    settle();
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_tcyc", 64'(tcyc_o), 64'h0);
    check("rst_ack_err", 64'({ack_o, err_o}), 64'h0);
    check("rst_state", 64'(state_o), 64'h0);
    check("rst_tadr", 64'(tadr_o), 64'h0);

    // ---- 1: single request from initiator 2 ----
    adr_i[2*AW +: AW] = 32'h8000_0010;
    request(2, 1'b1);
    settle();
    check("t1_tcyc_same_cycle", 64'(tcyc_o), 64'h0);
    next_cycle();
    check("t1_gnt", 64'(gnt_o), 64'b0100);
    check("t1_tcyc", 64'(tcyc_o), 64'h1);
    check("t1_tadr", 64'(tadr_o), 64'h8000_0010);
    check("t1_ack_wait", 64'(ack_o), 64'h0);
    next_cycle();
    tack_i = 1'b1;
    settle();
    check("t1_ack", 64'(ack_o), 64'b0100);
    // owner drops cyc in the ack cycle: ack still forwarded, target side goes quiet
    request(2, 1'b0);
    settle();
    check("t1_ack_on_release", 64'(ack_o), 64'b0100);
    check("t1_tcyc_release", 64'(tcyc_o), 64'h0);
    check("t1_tadr_release", 64'(tadr_o), 64'h0);
    next_cycle();
    settle();
    check("t1_idle_gnt", 64'(gnt_o), 64'h0);
    check("t1_idle_ack_ignored", 64'(ack_o), 64'h0);
    tack_i = 1'b0;
    adr_i[2*AW +: AW] = 32'h1000_0200;

    // ---- 2: all four request simultaneously, one ack each ----
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cyc_i = '1;
    stb_i = '1;
    while (exp_q.size() > 0) begin
      logic [N-1:0] want;
      int w;
      want = exp_q.pop_front();
      w = 0;
      for (int i = 0; i < N; i++) if (want[i]) w = i;
      next_cycle();
      check($sformatf("t2_gnt_%0d", w), 64'(gnt_o), 64'(want));
      check($sformatf("t2_tadr_%0d", w), 64'(tadr_o), 64'(32'h1000_0000 + 32'(w) * 32'h100));
      tack_i = 1'b1;
      request(w, 1'b0);
      settle();
      check($sformatf("t2_ack_%0d", w), 64'(ack_o), 64'(want));
      next_cycle();
      tack_i = 1'b0;
      settle();
      check($sformatf("t2_idle_%0d", w), 64'({gnt_o, tcyc_o}), 64'h0);
      request(w, 1'b1);
    end
    quiet_bus();
    next_cycle();
    next_cycle();

    // ---- 3: owner 1 holds cyc over 4 beats while 3 waits ----
    do_reset();
    request(1, 1'b1);
    request(3, 1'b1);
    next_cycle();
    tack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      settle();
      check($sformatf("t3_gnt_beat%0d", b), 64'(gnt_o), 64'b0010);
      check($sformatf("t3_ack_beat%0d", b), 64'(ack_o), 64'b0010);
      next_cycle();
    end
    tack_i = 1'b0;
    request(1, 1'b0);
    next_cycle();
    check("t3_idle_gnt", 64'(gnt_o), 64'h0);
    next_cycle();
    check("t3_gnt_next", 64'(gnt_o), 64'b1000);
    check("t3_tadr_next", 64'(tadr_o), 64'h1000_0300);
    quiet_bus();
    next_cycle();

    // ---- 4: reset pulse while owner 0 is active ----
    do_reset();
    request(0, 1'b1);
    next_cycle();
    check("t4_gnt_before", 64'(gnt_o), 64'b0001);
    tack_i  = 1'b1;
    reset_i = 1'b1;
    next_cycle();
    reset_i = 1'b0;
    settle();
    check("t4_after_rst", 64'({gnt_o, ack_o, tcyc_o}), 64'h0);
    tack_i = 1'b0;
    request(1, 1'b1);
    next_cycle();
    check("t4_winner", 64'(gnt_o), 64'b0001);
    quiet_bus();
    next_cycle();

    // ---- 6: error response to owner 3 ----
    do_reset();
    request(3, 1'b1);
    we_i[3]               = 1'b1;
    sel_i[3*SW +: SW]     = 4'b1010;
    dat_w_i[3*DW +: DW]   = 32'hDEAD_BEEF;
    next_cycle();
    request(0, 1'b1);
    check("t6_gnt", 64'(gnt_o), 64'b1000);
    check("t6_twe_tsel", 64'({twe_o, tsel_o}), 64'b11010);
    check("t6_tdat_w", 64'(tdat_w_o), 64'hDEAD_BEEF);
    terr_i   = 1'b1;
    tdat_r_i = 32'h1234_5678;
    settle();
    check("t6_err", 64'(err_o), 64'b1000);
    check("t6_ack", 64'(ack_o), 64'h0);
    check("t6_dat_r3", 64'(dat_r_o[3*DW +: DW]), 64'h1234_5678);
    terr_i = 1'b0;
    request(3, 1'b0);
    we_i[3] = 1'b0;
    next_cycle();
    next_cycle();
    check("t6_next_owner", 64'(gnt_o), 64'b0001);
    quiet_bus();
    next_cycle();

`ifdef WB_ARB_TIMEOUT_EN
    // ---- 5: watchdog on a silent target ----
    do_reset();
    request(2, 1'b1);
    next_cycle();
    request(0, 1'b1);
    for (int k = 0; k < TO; k++) begin
      settle();
      check($sformatf("t5_no_err_%0d", k), 64'({err_o, tcyc_o}), 64'b00001);
      next_cycle();
    end
    settle();
    check("t5_err_pulse", 64'(err_o), 64'b0100);
    check("t5_tcyc_forced", 64'({tcyc_o, tstb_o}), 64'h0);
    next_cycle();
    check("t5_drain", 64'({state_o, err_o, tcyc_o}), 64'({2'd2, 4'b0000, 1'b0}));
    next_cycle();
    check("t5_drain_hold", 64'({gnt_o, tcyc_o}), 64'({4'b0100, 1'b0}));
    request(2, 1'b0);
    next_cycle();
    check("t5_idle", 64'(gnt_o), 64'h0);
    next_cycle();
    check("t5_next_owner", 64'(gnt_o), 64'b0001);
`else
    // ---- 5 (default build): a silent target keeps the owner waiting ----
    do_reset();
    request(2, 1'b1);
    for (int k = 0; k < 20; k++) next_cycle();
    check("t5_stuck_tcyc", 64'({tcyc_o, gnt_o}), 64'({1'b1, 4'b0100}));
    check("t5_stuck_no_err", 64'(err_o), 64'h0);
`endif
    quiet_bus();
    next_cycle();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
